// File: rtl/paddsb_accum_seq_if.sv
// Producer/consumer handshake bundle for the packed saturating-sum sequencer.
// The master side starts reductions, supplies input beats and accepts the result.
interface paddsb_accum_seq_if #(
  parameter int CNT_W = 5
) ();
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [3:0]       sat_flag;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, sat_flag, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, sat_flag, busy
  );
endinterface

// File: rtl/paddsb_accum_seq.sv
// Reduces a stream of packed 4x4-bit signed words into one per-lane saturating sum.
// It also keeps sticky per-lane saturation flags for the current reduction.
module PADDSB_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic [3:0]  ovf
);
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [3:0] wrap;
    assign wrap          = a[4*i +: 4] + b[4*i +: 4];
    // Overflow only when both operands share a sign and the wrapped result flips it.
    assign ovf[i]        = (a[4*i+3] == b[4*i+3]) && (wrap[3] != a[4*i+3]);
    assign sum[4*i +: 4] = ovf[i] ? (a[4*i+3] ? 4'b1000 : 4'b0111) : wrap;
  end
endmodule

// state | meaning
// IDLE  | waiting for start; last result and sat_flag still visible
// ACCUM | accepting beats, cnt counts the beats still to come
// DONE  | result offered on res_data until the consumer takes it
module paddsb_accum_seq #(
  parameter int CNT_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  paddsb_accum_seq_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [15:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sat;
  logic [15:0]      step_sum;
  logic [3:0]       step_ovf;

  PADDSB_16bit u_add (
    .a   (acc),
    .b   (bus.in_data),
    .sum (step_sum),
    .ovf (step_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= 16'h0000;
      cnt   <= CNT_ZERO;
      sat   <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc <= 16'h0000;
            sat <= 4'h0;
            if (bus.len != CNT_ZERO) begin
              cnt   <= bus.len;
              state <= ACCUM;
            end else begin
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc <= step_sum;
            sat <= sat | step_ovf;
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready depends on state only so the producer never sees a combinational loop.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.res_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.res_data  = acc;
  assign bus.sat_flag  = sat;
endmodule

// File: tb/tb_paddsb_accum_seq.sv
// Bench for paddsb_accum_seq: table-driven reductions, hand-written corner sequences
// and random streams against a step-by-step saturating lane model.
module tb_paddsb_accum_seq;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  paddsb_accum_seq_if #(.CNT_W(5)) bus ();

  paddsb_accum_seq #(.CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  sat;
  } exp_t;

  typedef struct packed {
    logic [4:0]        n;
    logic [7:0][15:0]  w;
    logic [3:0]        gap;
    logic [2:0]        hold;
    logic [15:0]       er;
    logic [3:0]        es;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_step(input exp_t cur, input logic [15:0] d);
    exp_t nxt;
    int   s;
    nxt = cur;
    for (int i = 0; i < 4; i++) begin
      s = int'($signed(cur.res[4*i +: 4])) + int'($signed(d[4*i +: 4]));
      if (s > 7) begin
        s = 7;
        nxt.sat[i] = 1'b1;
      end else if (s < -8) begin
        s = -8;
        nxt.sat[i] = 1'b1;
      end
      nxt.res[4*i +: 4] = s[3:0];
    end
    return nxt;
  endfunction

  // One full reduction: start, beats (optional bubble after beat 0 with ignored start
  // pulses), latency check, optional backpressure with ignored starts, then handshake.
  task automatic do_red(input string tag, input int n, input logic [7:0][15:0] w,
                        input int gap, input int hold, input exp_t e);
    exp_t got;
    int   waited;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = 5'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'hDEAD;
      if (i == 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.start = 1'b1;
          bus.len   = 5'd1;
          chk({tag, "_bubble_busy"}, {31'b0, bus.busy}, 32'd1);
          @(posedge clk); #1;
          bus.start = 1'b0;
        end
      end
    end
    chk({tag, "_latency"}, {31'b0, bus.res_valid}, 32'd1);
    waited = 0;
    while (!bus.res_valid && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.res_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: res_valid never rose, expected 1", tag);
    end
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, "_res"}, {16'b0, bus.res_data}, {16'b0, got.res});
      chk({tag, "_sat"}, {28'b0, bus.sat_flag}, {28'b0, got.sat});
      for (int h = 0; h < hold; h++) begin
        bus.start = 1'b1;
        bus.len   = 5'd3;
        @(posedge clk); #1;
        chk({tag, "_hold_valid"}, {31'b0, bus.res_valid}, 32'd1);
        chk({tag, "_hold_res"}, {16'b0, bus.res_data}, {16'b0, got.res});
        chk({tag, "_hold_sat"}, {28'b0, bus.sat_flag}, {28'b0, got.sat});
      end
      bus.res_ready = 1'b1;
      bus.start     = (hold > 0);
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      chk({tag, "_idle_busy"}, {31'b0, bus.busy}, 32'd0);
      chk({tag, "_idle_valid"}, {31'b0, bus.res_valid}, 32'd0);
      chk({tag, "_idle_sat"}, {28'b0, bus.sat_flag}, {28'b0, got.sat});
    end
  endtask

  initial begin
    logic [7:0][15:0] w;
    exp_t             e;
    int               n;

    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.res_ready = 1'b0;
    rst_n         = 1'b0;

    vecs[0] = '{n: 5'd3, w: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0F0F, 16'h2222, 16'h1111},
                gap: 4'd2, hold: 3'd0, er: 16'h3232, es: 4'h0};
    vecs[1] = '{n: 5'd2, w: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1818, 16'h7788},
                gap: 4'd0, hold: 3'd3, er: 16'h7F98, es: 4'b1001};
    vecs[2] = '{n: 5'd3, w: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h000F, 16'h0001, 16'h0007},
                gap: 4'd0, hold: 3'd0, er: 16'h0006, es: 4'b0001};
    vecs[3] = '{n: 5'd3, w: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0007, 16'h000F},
                gap: 4'd1, hold: 3'd0, er: 16'h0007, es: 4'b0000};
    vecs[4] = '{n: 5'd0, w: '0, gap: 4'd0, hold: 3'd5, er: 16'h0000, es: 4'h0};
    vecs[5] = '{n: 5'd2, w: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h8888},
                gap: 4'd0, hold: 3'd0, er: 16'h8888, es: 4'hF};

    #12;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("rst_res_data", {16'b0, bus.res_data}, 32'd0);
    chk("rst_sat", {28'b0, bus.sat_flag}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a reduction discards the partial sum.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = 5'd4;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1111;
    @(posedge clk); #1;
    bus.in_data  = 16'h2121;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("mid_acc_before_rst", {16'b0, bus.res_data}, 32'h3232);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("mid_rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_acc", {16'b0, bus.res_data}, 32'd0);
    #3 rst_n = 1'b1;
    w = '0;
    w[0] = 16'h1234;
    do_red("after_rst", 1, w, 0, 0, '{res: 16'h1234, sat: 4'h0});

    for (int k = 0; k < 6; k++) begin
      do_red($sformatf("vec%0d", k), int'(vecs[k].n), vecs[k].w, int'(vecs[k].gap),
             int'(vecs[k].hold), '{res: vecs[k].er, sat: vecs[k].es});
    end

    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 8));
      e = '{res: 16'h0000, sat: 4'h0};
      w = '0;
      for (int i = 0; i < n; i++) begin
        w[i] = 16'($urandom);
        e    = model_step(e, w[i]);
      end
      do_red($sformatf("rand%0d", r), n, w, int'($urandom_range(0, 2)), 0, e);
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
